// File: rtl/manycore_pe_if.sv
// Per-tile router bundle: five flit ports (E, W, N, S, LOCAL) with valid/credit
// handshakes, shared by mesh neighbours and the local network interface.
interface interface_pe #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 32
) (
    input logic clock,
    input logic reset
);
    logic [4:0][FLIT_WIDTH-1:0] data_i;
    logic [4:0]                 rx;
    logic [4:0]                 credit_o;
    logic [4:0][FLIT_WIDTH-1:0] data_o;
    logic [4:0]                 tx;
    logic [4:0]                 credit_i;
    logic [4:0]                 clock_rx;
    logic [4:0]                 clock_tx;

    modport PE (
        input  clock,
        input  reset,
        input  data_i,
        input  rx,
        output credit_o,
        output data_o,
        output tx,
        input  credit_i,
        input  clock_rx,
        output clock_tx
    );
endinterface

// File: rtl/manycore_pe.sv
// Mesh tile router: five buffered inputs, XY routing, round-robin single-grant
// arbiter and wormhole connections held for header + size + N payload flits.
module manycore_pe #(
    parameter int          MEMORY_BUS_WIDTH   = 32,
    parameter int          FLIT_WIDTH         = 32,
    parameter int          MEMORY_SIZE        = 65536,
    parameter int          BOOT_SIZE          = 2048,
    parameter logic [31:0] ADDRESS            = 32'h0,
    parameter int          INTERLEAVING_GRAIN = 3,
    parameter int          BUFFER_DEPTH       = 4
) (
    input logic     clock,
    input logic     reset,
    interface_pe.PE pe_if
);
    localparam int NP = 5;
    localparam int HW = FLIT_WIDTH / 2;
    localparam int QW = FLIT_WIDTH / 4;
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam logic [FLIT_WIDTH-1:0] ADDR = FLIT_WIDTH'(ADDRESS);
    localparam logic [QW-1:0] OWN_X = ADDR[HW-1:QW];
    localparam logic [QW-1:0] OWN_Y = ADDR[QW-1:0];

    function automatic logic [2:0] xy_route(input logic [FLIT_WIDTH-1:0] hdr);
        logic [QW-1:0] dx;
        logic [QW-1:0] dy;
        dx = hdr[HW-1:QW];
        dy = hdr[QW-1:0];
        if (dx > OWN_X)      return 3'd0;
        else if (dx < OWN_X) return 3'd1;
        else if (dy > OWN_Y) return 3'd2;
        else if (dy < OWN_Y) return 3'd3;
        return 3'd4;
    endfunction

    logic [NP-1:0]                 fifo_empty, fifo_full, push, pop;
    logic [NP-1:0][FLIT_WIDTH-1:0] fifo_head;
    logic [NP-1:0]                 tx, xfer;
    logic [NP-1:0][FLIT_WIDTH-1:0] data_out;

    // stage: 0 = header next, 1 = size flit next, 2 = payload (remain left)
    logic [NP-1:0]                 in_busy_q, in_busy_d;
    logic [NP-1:0][2:0]            in_out_q, in_out_d;
    logic [NP-1:0][1:0]            stage_q, stage_d;
    logic [NP-1:0][FLIT_WIDTH-1:0] remain_q, remain_d;
    logic [NP-1:0]                 out_busy_q, out_busy_d;
    logic [NP-1:0][2:0]            out_src_q, out_src_d;
    logic [2:0]                    rr_q, rr_d;

    logic [NP-1:0][2:0] head_route;
    logic [NP-1:0]      req;
    logic               grant_valid;
    logic [2:0]         grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_fifo
            logic [FLIT_WIDTH-1:0] mem_q [BUFFER_DEPTH];
            logic [AW:0]           wr_ptr_q, rd_ptr_q;

            assign push[gi]       = pe_if.rx[gi] & ~fifo_full[gi];
            assign fifo_empty[gi] = (wr_ptr_q == rd_ptr_q);
            assign fifo_full[gi]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
            assign fifo_head[gi]  = mem_q[rd_ptr_q[AW-1:0]];

            always_ff @(posedge clock) begin
                if (push[gi]) mem_q[wr_ptr_q[AW-1:0]] <= pe_if.data_i[gi];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (push[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop[gi])  rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    endgenerate

    assign pe_if.credit_o = ~fifo_full;
    assign pe_if.tx       = tx;
    assign pe_if.data_o   = data_out;
    assign pe_if.clock_tx = {NP{clock}};

    always_comb begin
        tx       = '0;
        xfer     = '0;
        data_out = '0;
        pop      = '0;
        for (int o = 0; o < NP; o++) begin
            tx[o]       = out_busy_q[o] && !fifo_empty[out_src_q[o]];
            data_out[o] = out_busy_q[o] ? fifo_head[out_src_q[o]] : '0;
            xfer[o]     = tx[o] & pe_if.credit_i[o];
        end
        for (int p = 0; p < NP; p++) begin
            pop[p] = in_busy_q[p] && xfer[in_out_q[p]];
        end
    end

    always_comb begin
        int idx;
        idx         = 0;
        in_busy_d   = in_busy_q;
        in_out_d    = in_out_q;
        stage_d     = stage_q;
        remain_d    = remain_q;
        out_busy_d  = out_busy_q;
        out_src_d   = out_src_q;
        rr_d        = rr_q;
        head_route  = '0;
        req         = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;

        for (int p = 0; p < NP; p++) begin
            head_route[p] = xy_route(fifo_head[p]);
            req[p] = !fifo_empty[p] && !in_busy_q[p] && !out_busy_q[head_route[p]];
        end
        for (int k = 0; k < NP; k++) begin
            idx = (int'(rr_q) + k) % NP;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(idx);
            end
        end

        // Release happens on the edge that moves the packet's last flit.
        for (int p = 0; p < NP; p++) begin
            if (pop[p]) begin
                case (stage_q[p])
                    2'd0: stage_d[p] = 2'd1;
                    2'd1: begin
                        if (fifo_head[p] == '0) begin
                            in_busy_d[p]            = 1'b0;
                            out_busy_d[in_out_q[p]] = 1'b0;
                        end else begin
                            stage_d[p]  = 2'd2;
                            remain_d[p] = fifo_head[p];
                        end
                    end
                    default: begin
                        if (remain_q[p] == FLIT_WIDTH'(1)) begin
                            in_busy_d[p]            = 1'b0;
                            out_busy_d[in_out_q[p]] = 1'b0;
                        end else begin
                            remain_d[p] = remain_q[p] - FLIT_WIDTH'(1);
                        end
                    end
                endcase
            end
        end

        if (grant_valid) begin
            in_busy_d[grant_idx]              = 1'b1;
            in_out_d[grant_idx]               = head_route[grant_idx];
            stage_d[grant_idx]                = 2'd0;
            out_busy_d[head_route[grant_idx]] = 1'b1;
            out_src_d[head_route[grant_idx]]  = grant_idx;
            rr_d = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_busy_q  <= '0;
            in_out_q   <= '0;
            stage_q    <= '0;
            remain_q   <= '0;
            out_busy_q <= '0;
            out_src_q  <= '0;
            rr_q       <= '0;
        end else begin
            in_busy_q  <= in_busy_d;
            in_out_q   <= in_out_d;
            stage_q    <= stage_d;
            remain_q   <= remain_d;
            out_busy_q <= out_busy_d;
            out_src_q  <= out_src_d;
            rr_q       <= rr_d;
        end
    end
endmodule

// File: tb/tb_manycore_pe.sv
// Bench for manycore_pe at tile (1,1): per-output expected-flit queues filled
// from XY routing of each injected packet, plus directed timing checks.
module tb_manycore_pe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    interface_pe #(.MEMORY_BUS_WIDTH(32), .FLIT_WIDTH(32)) pe_if (.clock(clk), .reset(rst));

    manycore_pe #(
        .MEMORY_BUS_WIDTH(32), .FLIT_WIDTH(32), .MEMORY_SIZE(65536), .BOOT_SIZE(2048),
        .ADDRESS(32'h0101), .INTERLEAVING_GRAIN(3), .BUFFER_DEPTH(4)
    ) dut (
        .clock(clk),
        .reset(rst),
        .pe_if(pe_if)
    );

    logic        rx_drv  [5];
    logic [31:0] din_drv [5];
    logic [4:0]  credit_drv;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pe_if.rx[i]     = rx_drv[i];
            pe_if.data_i[i] = din_drv[i];
        end
    end
    assign pe_if.credit_i = credit_drv;
    assign pe_if.clock_rx = {5{clk}};

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    logic [31:0] exp_q [5][$];
    int          xfer_cnt [5];
    int          xfer_edge [5][$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    // XY routing for tile (1,1), straight from the addressing rules.
    function automatic int route(input logic [31:0] hdr);
        int dx, dy;
        dx = int'(hdr[15:8]);
        dy = int'(hdr[7:0]);
        if (dx > 1) return 0;
        if (dx < 1) return 1;
        if (dy > 1) return 2;
        if (dy < 1) return 3;
        return 4;
    endfunction

    task automatic expect_pkt(input logic [31:0] f[$]);
        int o;
        o = route(f[0]);
        foreach (f[i]) exp_q[o].push_back(f[i]);
    endtask

    // Called just after a rising edge; sends one flit per edge while credit allows.
    task automatic inject(input int p, input logic [31:0] f[$]);
        foreach (f[i]) begin
            int tries;
            tries = 0;
            while (!pe_if.credit_o[p] && tries < 200) begin
                rx_drv[p] = 1'b0;
                @(posedge clk); #1;
                tries++;
            end
            if (tries >= 200) begin
                total_cnt++;
                $display("FAIL inject_timeout port=%0d flit=%0d: credit_o stayed 0, required 1", p, i);
                rx_drv[p] = 1'b0;
                return;
            end
            rx_drv[p]  = 1'b1;
            din_drv[p] = f[i];
            @(posedge clk); #1;
        end
        rx_drv[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                exp_q[3].size() + exp_q[4].size()) != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        total_cnt++;
        if (t < 300) pass_cnt++;
        else $display("FAIL drain_timeout: pending E=%0d W=%0d N=%0d S=%0d L=%0d, required all 0",
                      exp_q[0].size(), exp_q[1].size(), exp_q[2].size(),
                      exp_q[3].size(), exp_q[4].size());
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Compare process: every transfer must be the next expected flit on that output.
    always @(negedge clk) begin
        if (!rst) begin
            for (int o = 0; o < 5; o++) begin
                if (pe_if.tx[o] && pe_if.credit_i[o]) begin
                    xfer_cnt[o]++;
                    xfer_edge[o].push_back(cyc + 1);
                    if (exp_q[o].size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_flit out=%0d: actual=%h required=no transfer",
                                 o, pe_if.data_o[o]);
                    end else begin
                        check($sformatf("flit_out%0d", o), pe_if.data_o[o], exp_q[o].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pk [$];
        logic [31:0] pk2 [$];
        int          base [5];
        int          base5;
        int          t;

        for (int i = 0; i < 5; i++) begin
            rx_drv[i]   = 1'b0;
            din_drv[i]  = '0;
            xfer_cnt[i] = 0;
        end
        credit_drv = 5'h1F;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_tx", 32'(pe_if.tx), 32'h0);
        check("reset_credit_o", 32'(pe_if.credit_o), 32'h1F);
        for (int o = 0; o < 5; o++) check($sformatf("reset_data_o%0d", o), pe_if.data_o[o], 32'h0);

        // LOCAL -> LOCAL, header leaves two edges after it is written.
        pk = '{32'h0101, 32'h2, 32'hA, 32'hB};
        expect_pkt(pk);
        rx_drv[4] = 1'b1; din_drv[4] = 32'h0101;
        @(posedge clk); #1;
        din_drv[4] = 32'h2;
        check("local_tx_before_grant", 32'(pe_if.tx[4]), 32'h0);
        @(posedge clk); #1;
        din_drv[4] = 32'hA;
        check("local_tx_after_grant", 32'(pe_if.tx[4]), 32'h1);
        check("local_hdr_on_data_o", pe_if.data_o[4], 32'h0101);
        @(posedge clk); #1;
        din_drv[4] = 32'hB;
        @(posedge clk); #1;
        rx_drv[4] = 1'b0;
        wait_drain();

        // Four directions from LOCAL.
        for (int o = 0; o < 5; o++) base[o] = xfer_cnt[o];
        pk = '{32'h0201, 32'h1, 32'hE0}; expect_pkt(pk); inject(4, pk);
        pk = '{32'h0001, 32'h1, 32'hE1}; expect_pkt(pk); inject(4, pk);
        pk = '{32'h0102, 32'h1, 32'hE2}; expect_pkt(pk); inject(4, pk);
        pk = '{32'h0100, 32'h1, 32'hE3}; expect_pkt(pk); inject(4, pk);
        wait_drain();
        check("east_flit_count",  32'(xfer_cnt[0] - base[0]), 32'd3);
        check("west_flit_count",  32'(xfer_cnt[1] - base[1]), 32'd3);
        check("north_flit_count", 32'(xfer_cnt[2] - base[2]), 32'd3);
        check("south_flit_count", 32'(xfer_cnt[3] - base[3]), 32'd3);
        check("local_flit_count", 32'(xfer_cnt[4] - base[4]), 32'd0);

        // WEST and SOUTH contend for EAST: WEST first, SOUTH after, no interleave.
        pk  = '{32'h0201, 32'h2, 32'h11, 32'h12};
        pk2 = '{32'h0201, 32'h1, 32'h21};
        expect_pkt(pk);
        expect_pkt(pk2);
        fork
            inject(1, pk);
            inject(3, pk2);
        join
        wait_drain();

        // Back-pressure on EAST mid-packet.
        pk = '{32'h0201, 32'h6, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
        expect_pkt(pk);
        base5 = xfer_cnt[0];
        fork
            inject(4, pk);
            begin
                t = 0;
                while (xfer_cnt[0] < base5 + 2 && t < 100) begin
                    @(posedge clk);
                    t++;
                end
                #1 credit_drv[0] = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_tx_held", 32'(pe_if.tx[0]), 32'h1);
                    check("bp_data_held", pe_if.data_o[0], 32'hB0);
                end
                check("bp_local_credit_low", 32'(pe_if.credit_o[4]), 32'h0);
                @(posedge clk); #1;
                credit_drv[0] = 1'b1;
            end
        join
        wait_drain();

        // Zero-size packet followed by another to the same output.
        xfer_edge[2].delete();
        pk  = '{32'h0102, 32'h0};
        pk2 = '{32'h0102, 32'h1, 32'h77};
        expect_pkt(pk);
        expect_pkt(pk2);
        inject(4, {pk, pk2});
        wait_drain();
        check("size0_north_xfers", 32'(xfer_edge[2].size()), 32'd5);
        if (xfer_edge[2].size() >= 3) begin
            check("size0_two_flits_back_to_back", 32'(xfer_edge[2][1] - xfer_edge[2][0]), 32'd1);
            check("size0_next_hdr_gap", 32'(xfer_edge[2][2] - xfer_edge[2][1]), 32'd2);
        end

        // Reset while a packet is stalled on EAST.
        credit_drv[0] = 1'b0;
        rx_drv[4] = 1'b1; din_drv[4] = 32'h0201;
        @(posedge clk); #1;
        din_drv[4] = 32'h3;
        @(posedge clk); #1;
        din_drv[4] = 32'hC1;
        @(posedge clk); #1;
        rx_drv[4] = 1'b0;
        check("stalled_tx_before_reset", 32'(pe_if.tx[0]), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_tx", 32'(pe_if.tx), 32'h0);
        check("midreset_credit_o", 32'(pe_if.credit_o), 32'h1F);
        for (int o = 0; o < 5; o++) check($sformatf("midreset_data_o%0d", o), pe_if.data_o[o], 32'h0);
        credit_drv[0] = 1'b1;
        pk = '{32'h0201, 32'h1, 32'h55};
        expect_pkt(pk);
        inject(4, pk);
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
